// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared types and segment pattern constants for the seven-segment scan decoder.
// Patterns are active-low, bit0 = segment a ... bit6 = segment g.
// Optional build macro used by the decoder: SEVEN_SEG_DEC_HEX_EN (hex letters A-F).
package seven_seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  // Decimal digit patterns (gfedcba, active-low)
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0011000;

  // Hex letter patterns, only recognised when hex decoding is built in
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  // All segments dark
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Nibble reported for a pattern that is not in the table
  localparam digit_t DIGIT_BAD = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Display-bus snoop inputs plus the val/rdy frame output of the scan decoder.
// master = the decoder, slave = whoever drives the display bus and consumes frames.
interface seven_seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
) ();

  seven_seg_pkg::seg_t       seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      out_val;
  logic                      out_rdy;
  logic [4*NUM_DIGITS-1:0]   out_data;
  logic                      out_err;

  modport master (
    input  seg,
    input  an,
    input  out_rdy,
    output out_val,
    output out_data,
    output out_err
  );

  modport slave (
    output seg,
    output an,
    output out_rdy,
    input  out_val,
    input  out_data,
    input  out_err
  );

endinterface

// File: rtl/seven_seg_scan_decoder_pattern_decode.sv
// Combinational segment-pattern to nibble lookup.
// With SEVEN_SEG_DEC_HEX_EN defined the letters A-F are accepted as well.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  seg_t   seg,
  output digit_t value,
  output logic   err
);

  // Table lookup; anything unrecognised reports 4'hF with the error flag
  always_comb begin
    value = DIGIT_BAD;
    err   = 1'b1;
    case (seg)
      SEG_0: begin value = 4'h0; err = 1'b0; end
      SEG_1: begin value = 4'h1; err = 1'b0; end
      SEG_2: begin value = 4'h2; err = 1'b0; end
      SEG_3: begin value = 4'h3; err = 1'b0; end
      SEG_4: begin value = 4'h4; err = 1'b0; end
      SEG_5: begin value = 4'h5; err = 1'b0; end
      SEG_6: begin value = 4'h6; err = 1'b0; end
      SEG_7: begin value = 4'h7; err = 1'b0; end
      SEG_8: begin value = 4'h8; err = 1'b0; end
      SEG_9: begin value = 4'h9; err = 1'b0; end
`ifdef SEVEN_SEG_DEC_HEX_EN
      SEG_A: begin value = 4'hA; err = 1'b0; end
      SEG_B: begin value = 4'hB; err = 1'b0; end
      SEG_C: begin value = 4'hC; err = 1'b0; end
      SEG_D: begin value = 4'hD; err = 1'b0; end
      SEG_E: begin value = 4'hE; err = 1'b0; end
      SEG_F: begin value = 4'hF; err = 1'b0; end
`else
`endif
      default: begin
        value = DIGIT_BAD;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Seven-segment scan decoder: snoops a multiplexed active-low display bus,
// filters each digit dwell for stability, assembles one value per full scan
// and offers it on a val/rdy output. Build option: SEVEN_SEG_DEC_HEX_EN.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  seven_seg_scan_decoder_if.master  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Previous-sample and stability tracking
  logic [NUM_DIGITS-1:0]   an_q_reg;
  seg_t                    seg_q_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [CNT_W-1:0]        cnt_next;

  // Frame staging
  logic [NUM_DIGITS-1:0]   mask_reg;
  logic [NUM_DIGITS-1:0]   mask_next;
  logic [NUM_DIGITS-1:0]   mask_after;
  digit_t                  nib_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   err_stage_reg;
  logic [4*NUM_DIGITS-1:0] frame_next;
  logic [NUM_DIGITS-1:0]   frame_err;

  // FSM and output registers
  state_t                  state_reg;
  state_t                  state_next;
  logic                    out_val_reg;
  logic                    out_val_next;
  logic [4*NUM_DIGITS-1:0] out_data_reg;
  logic [4*NUM_DIGITS-1:0] out_data_next;
  logic                    out_err_reg;
  logic                    out_err_next;

  // Per-sample decode
  logic                    sample_valid;
  logic                    sample_same;
  logic                    stable_hit;
  logic                    capture;
  logic [IDX_W-1:0]        cap_idx;
  digit_t                  dec_value;
  logic                    dec_err;

  seven_seg_pattern_decode u_decode (
    .seg   (bus.seg),
    .value (dec_value),
    .err   (dec_err)
  );

  // Locate the single low enable; the index is only meaningful when the sample is valid
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!bus.an[i]) begin
        cap_idx = IDX_W'(i);
      end
    end
  end

  // Stability counter next value and the dwell-completion strobe
  always_comb begin
    sample_valid = $onehot(~bus.an);
    sample_same  = (bus.an == an_q_reg) && (bus.seg == seg_q_reg);
    cnt_next     = '0;
    if (sample_valid) begin
      if (sample_same) begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
      end else begin
        cnt_next = CNT_W'(1);
      end
    end
    // A new dwell reaching the threshold; with a threshold of 1 every change counts
    stable_hit = sample_valid && (cnt_next == CNT_MAX) &&
                 (!sample_same || (cnt_reg != CNT_MAX));
  end

  // Frame view as it would look after this edge's capture lands
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_frame
      logic hit;
      assign hit = stable_hit && (cap_idx == IDX_W'(gi));
      assign mask_after[gi]        = mask_reg[gi] | hit;
      assign frame_next[4*gi +: 4] = hit ? dec_value : nib_reg[gi];
      assign frame_err[gi]         = hit ? dec_err : err_stage_reg[gi];
    end
  endgenerate

  // Next-state and output-register logic for the collect/present handshake
  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    out_val_next  = out_val_reg;
    out_data_next = out_data_reg;
    out_err_next  = out_err_reg;
    capture       = 1'b0;
    case (state_reg)
      COLLECT: begin
        capture = stable_hit;
        if (stable_hit) begin
          mask_next = mask_after;
          if (&mask_after) begin
            out_data_next = frame_next;
            out_err_next  = |frame_err;
            out_val_next  = 1'b1;
            mask_next     = '0;
            state_next    = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (out_val_reg && bus.out_rdy) begin
          out_val_next = 1'b0;
          state_next   = COLLECT;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sample history, stability count, capture mask and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q_reg     <= '1;
      seg_q_reg    <= '0;
      cnt_reg      <= '0;
      mask_reg     <= '0;
      out_val_reg  <= 1'b0;
      out_data_reg <= '0;
      out_err_reg  <= 1'b0;
    end else begin
      an_q_reg     <= bus.an;
      seg_q_reg    <= bus.seg;
      cnt_reg      <= cnt_next;
      mask_reg     <= mask_next;
      out_val_reg  <= out_val_next;
      out_data_reg <= out_data_next;
      out_err_reg  <= out_err_next;
    end
  end

  // Staging slots; a repeat capture of the same digit simply overwrites its slot
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          nib_reg[gi]       <= '0;
          err_stage_reg[gi] <= 1'b0;
        end else if (capture && (cap_idx == IDX_W'(gi))) begin
          nib_reg[gi]       <= dec_value;
          err_stage_reg[gi] <= dec_err;
        end
      end
    end
  endgenerate

  assign bus.out_val  = out_val_reg;
  assign bus.out_data = out_data_reg;
  assign bus.out_err  = out_err_reg;

endmodule
